// File: rtl/operand_loader.sv
// Operand loader: streams operand words into the engine input RAM, zero-pads
// short batches, pulses start, then waits for the engine to report done.
module operand_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              start,
    input  logic              eng_done,
    output logic              busy,
    output logic [ADDR_W:0]   loaded_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] LOAD      = 2'd0;
    localparam logic [1:0] PAD       = 2'd1;
    localparam logic [1:0] START     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_FINAL = (ADDR_W + 1)'(DEPTH - 1);

    logic [1:0]      state;
    logic [ADDR_W:0] wr_ptr;
    logic            handshake;
    logic            at_final;

    assign in_ready  = (state == LOAD) & ~rst;
    assign handshake = in_valid & in_ready;
    assign at_final  = (wr_ptr == PTR_FINAL);

    // A full batch skips PAD; a short batch pads the remaining addresses with zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
            loaded_cnt <= '0;
        end else begin
            ram_we <= 1'b0;
            start  <= 1'b0;
            case (state)
                LOAD: begin
                    if (handshake) begin
                        ram_we     <= 1'b1;
                        ram_addr   <= wr_ptr[ADDR_W-1:0];
                        ram_wdata  <= in_data;
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        busy       <= 1'b1;
                        loaded_cnt <= wr_ptr + PTR_ONE;
                        if (at_final) begin
                            state <= START;
                        end else if (in_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    ram_we    <= 1'b1;
                    ram_addr  <= wr_ptr[ADDR_W-1:0];
                    ram_wdata <= '0;
                    wr_ptr    <= wr_ptr + PTR_ONE;
                    if (at_final) begin
                        state <= START;
                    end
                end
                START: begin
                    start  <= 1'b1;
                    wr_ptr <= '0;
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus pushes expected RAM writes and
// start pulses; a negedge monitor pops and compares them as the DUT emits them.
module tb_operand_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              start;
    logic              eng_done;
    logic              busy;
    logic [ADDR_W:0]   loaded_cnt;

    typedef struct packed {
        logic              is_start;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tb_ptr   = 0;
    logic prev_we  = 1'b0;

    operand_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .start      (start),
        .eng_done   (eng_done),
        .busy       (busy),
        .loaded_cnt (loaded_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: actual=event expected=none", name);
    endtask

    // Monitor: every write and start pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (start === 1'b1) begin
            checkOutput("start_no_we", {31'd0, ram_we}, 32'd0);
            checkOutput("start_after_write", {31'd0, prev_we}, 32'd1);
            if (exp_q.size() == 0) begin
                failNow("unexpected_start");
            end else begin
                e = exp_q.pop_front();
                checkOutput("start_kind", {31'd0, e.is_start}, 32'd1);
            end
        end else if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                failNow("unexpected_write");
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_kind", {31'd0, e.is_start}, 32'd0);
                checkOutput("write_addr", {28'd0, ram_addr}, {28'd0, e.addr});
                checkOutput("write_data", {16'd0, ram_wdata}, {16'd0, e.data});
            end
        end
        prev_we = (ram_we === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStart();
        exp_t e;
        e.is_start = 1'b1;
        e.addr     = '0;
        e.data     = '0;
        exp_q.push_back(e);
        tb_ptr = 0;
    endtask

    task automatic pushWrite(input logic [DATA_W-1:0] data);
        exp_t e;
        e.is_start = 1'b0;
        e.addr     = 4'(tb_ptr);
        e.data     = data;
        exp_q.push_back(e);
        tb_ptr++;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        eng_done = 1'b0;
        step();
        exp_q.delete();
        tb_ptr = 0;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        checkOutput("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        checkOutput("rst_start", {31'd0, start}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_loaded_cnt", {27'd0, loaded_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // One word per call; the expected write (and any padding/start) is queued at handshake.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last, input logic gap);
        logic hs;
        hs       = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        if (!hs) begin
            failNow("handshake_timeout");
        end else begin
            pushWrite(data);
            if (tb_ptr == DEPTH) begin
                pushStart();
            end else if (last) begin
                while (tb_ptr < DEPTH) pushWrite(16'h0000);
                pushStart();
            end
        end
        if (gap) step();
    endtask

    task automatic waitStart(input int exp_cycles, input string name);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        checkOutput(name, n, exp_cycles);
        checkOutput("start_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic finishEngine();
        step();
        checkOutput("start_one_cycle", {31'd0, start}, 32'd0);
        repeat (4) step();
        checkOutput("wait_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("wait_busy", {31'd0, busy}, 32'd1);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checkOutput("done_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        eng_done = 1'b0;
        doReset();

        // Full batch, continuous valid, no in_last.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(16'(i), 1'b0, 1'b0);
        waitStart(1, "start_lat_full");
        checkOutput("loaded_full", {27'd0, loaded_cnt}, 32'd16);
        finishEngine();

        // Spurious eng_done while idle in LOAD.
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checkOutput("spurious_idle_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("spurious_idle_busy", {31'd0, busy}, 32'd0);

        // Early last after three words, with a spurious eng_done mid-batch.
        applyStimulus(16'hAAAA, 1'b0, 1'b0);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checkOutput("spurious_load_busy", {31'd0, busy}, 32'd1);
        checkOutput("spurious_load_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("loaded_first", {27'd0, loaded_cnt}, 32'd1);
        applyStimulus(16'hBBBB, 1'b0, 1'b0);
        applyStimulus(16'hCCCC, 1'b1, 1'b0);
        waitStart(14, "start_lat_pad13");
        checkOutput("loaded_short", {27'd0, loaded_cnt}, 32'd3);
        finishEngine();
        checkOutput("loaded_hold", {27'd0, loaded_cnt}, 32'd3);

        // Gapped valid.
        for (int i = 0; i < DEPTH; i++) applyStimulus(16'h1000 + 16'(i), 1'b0, 1'b1);
        checkOutput("loaded_gapped", {27'd0, loaded_cnt}, 32'd16);
        finishEngine();

        // in_last on the sixteenth word: no padding.
        for (int i = 0; i < DEPTH; i++) applyStimulus(16'h5A00 + 16'(i), (i == DEPTH - 1), 1'b0);
        waitStart(1, "start_lat_last16");
        finishEngine();

        // Reset after seven writes, then a two-word batch reset during PAD.
        for (int i = 0; i < 7; i++) applyStimulus(16'h7700 + 16'(i), 1'b0, 1'b0);
        doReset();
        applyStimulus(16'h1234, 1'b0, 1'b0);
        applyStimulus(16'h5678, 1'b1, 1'b0);
        repeat (3) step();
        doReset();

        // Reset during WAIT_DONE.
        for (int i = 0; i < DEPTH; i++) applyStimulus(16'hC000 + 16'(i), 1'b0, 1'b0);
        waitStart(1, "start_lat_pre_reset");
        repeat (2) step();
        doReset();

        // Single-word batch after the aborts: fifteen pad writes.
        applyStimulus(16'hBEEF, 1'b1, 1'b0);
        waitStart(16, "start_lat_pad15");
        checkOutput("loaded_single", {27'd0, loaded_cnt}, 32'd1);
        finishEngine();
        repeat (3) step();
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the approximate-multiplier engine.
- Accepts operand words over a valid/ready stream and writes them into the engine's input RAM at consecutive addresses.
- Zero-pads any unused addresses when a batch ends early, then issues the engine's start pulse.
- Holds off new input until the engine reports done, so the engine owns the RAM while it runs.

Parameters:
DATA_W, 16, width of one operand word / RAM data
ADDR_W, 4, input RAM address width; batch depth DEPTH = 2**ADDR_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_data  input  DATA_W  operand word
in_valid  input  1  in_data valid
in_last  input  1  qualifies in_data as final word of batch (sampled only on handshake)
in_ready  output  1  loader can accept a word
ram_we  output  1  input RAM write enable
ram_addr  output  ADDR_W  input RAM write address
ram_wdata  output  DATA_W  input RAM write data
start  output  1  one-cycle start pulse to engine controller
eng_done  input  1  engine done pulse
busy  output  1  high from first accepted word until eng_done
loaded_cnt  output  ADDR_W+1  real (non-pad) words in current/last batch, 1..DEPTH

Behaviour:
- One clock, synchronous active-high reset. Reset has priority over all events, including mid-batch and mid-wait.
- Reset values: state LOAD, wr_ptr 0, ram_we 0, ram_addr 0, ram_wdata 0, start 0, busy 0, loaded_cnt 0.
- in_ready = (state==LOAD) & ~rst, combinational from state.
- A handshake is in_valid & in_ready at a rising edge.
- All other outputs are registered.
- State LOAD:
  - On handshake: next cycle ram_we=1, ram_addr=wr_ptr, ram_wdata=in_data. Write latency is exactly 1 cycle. wr_ptr increments. busy=1. loaded_cnt=wr_ptr+1.
  - On the first handshake of a batch, loaded_cnt restarts from 1.
  - If the handshake has wr_ptr==DEPTH-1: go to START (in_last ignored; the batch is full).
  - Else if in_last=1: go to PAD.
  - No handshake: ram_we=0, hold state.
- State PAD:
  - One zero write per cycle: ram_we=1, ram_addr=wr_ptr, ram_wdata=0. wr_ptr increments.
  - After writing address DEPTH-1, go to START.
  - in_ready=0 throughout.
- State START:
  - start=1 for exactly one cycle. Its rising-edge cycle follows the final RAM write cycle by 1, so start never coincides with ram_we.
  - wr_ptr wraps to 0. Go to WAIT_DONE.
- State WAIT_DONE:
  - in_ready=0, ram_we=0, start=0.
  - On eng_done=1: busy=0, go to LOAD.
  - in_ready rises the cycle after eng_done is sampled.
- eng_done outside WAIT_DONE is ignored: no state change, no error.
- in_data/in_last are don't-care without a handshake. in_valid may drop between words with no effect.
- wr_ptr is ADDR_W+1 bits internally; ram_addr uses the low ADDR_W bits. No address is written twice per batch, and every address 0..DEPTH-1 is written exactly once per batch.
- loaded_cnt holds its value from batch completion until the first handshake of the next batch.

Test Plan:
- Full batch: DEPTH=16, 16 words 0x0001..0x0010, in_valid constant, in_last=0 → ram_we on 16 consecutive cycles, addr 0..15, data 0x0001..0x0010; start one cycle after last write; loaded_cnt=16; in_ready=0 until eng_done.
- Early last: 3 words 0xAAAA, 0xBBBB, 0xCCCC, third with in_last=1 → writes addr 0..2 with data, then addr 3..15 with 0x0000 on 13 consecutive cycles; single start pulse; loaded_cnt=3.
- Gapped valid: 16 words with in_valid toggling 1/0 → writes only on handshake cycles, addresses contiguous 0..15, exactly one start.
- Done handshake: eng_done pulsed 5 cycles after start → busy falls, in_ready=1 the next cycle; a second batch writes from addr 0 again; spurious eng_done during LOAD changes nothing.
- Reset mid-operation: rst asserted after 7 writes, and separately during PAD and during WAIT_DONE → next cycle all outputs at reset values, state LOAD; a new batch starts at addr 0 with no start pulse from the aborted batch.
- in_last on word 16: in_last=1 together with the DEPTH-th word → no PAD cycles; start follows the final write by one cycle.
